// File: rtl/numero_capture_if.sv
// Pixel stream, capture control and 11x11 digit image bundle between a video source and numero_capture.
interface numero_capture_if;
   logic                         iStart;
   logic                         iVsync;
   logic                         iPix_valid;
   logic [7:0]                   iPix;
   logic [9:0]                   iX;
   logic [9:0]                   iY;
   logic [10:0][10:0][7:0]       oNumero;
   logic                         oBusy;
   logic                         oValid;

   modport master (
      output iStart, iVsync, iPix_valid, iPix, iX, iY,
      input  oNumero, oBusy, oValid
   );

   modport slave (
      input  iStart, iVsync, iPix_valid, iPix, iX, iY,
      output oNumero, oBusy, oValid
   );
endinterface

// File: rtl/numero_capture.sv
// Captures a 44x44 window of a raster frame and box-downsamples it to an 11x11 8-bit digit image.
// Define NUMERO_CAPTURE_INVERT_EN to accumulate 255-pix instead of pix (dark-on-light digits).
//
// state       | meaning
// ST_IDLE     | no capture pending, oNumero holds
// ST_WAIT_FRM | capture requested, waiting for next iVsync, accumulators held at 0
// ST_CAPTURE  | accumulating window pixels, rows of oNumero written as cells finish
// ST_DONE     | last window pixel seen, oValid high, oNumero holds
module numero_capture #(
   parameter int X0 = 0,
   parameter int Y0 = 0
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   numero_capture_if.slave  bus
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_WAIT_FRM = 2'd1;
   localparam logic [1:0] ST_CAPTURE  = 2'd2;
   localparam logic [1:0] ST_DONE     = 2'd3;

   localparam logic [10:0] X_LO = 11'(X0);
   localparam logic [10:0] X_HI = 11'(X0 + 44);
   localparam logic [10:0] Y_LO = 11'(Y0);
   localparam logic [10:0] Y_HI = 11'(Y0 + 44);

   logic [1:0]             state;
   logic [1:0]             state_nxt;
   logic [11:0]            acc [11];
   logic [10:0][10:0][7:0] numero;

   logic [9:0]  dx;
   logic [9:0]  dy;
   logic [3:0]  col;
   logic [3:0]  row;
   logic        in_win;
   logic        accept;
   logic        take;
   logic        cell_end;
   logic        last_pix;
   logic        restart;
   logic        clear_acc;
   logic [7:0]  pix_val;
   logic [11:0] acc_sel;
   logic [11:0] sum;

   always_comb begin
      dx       = bus.iX - X_LO[9:0];
      dy       = bus.iY - Y_LO[9:0];
      in_win   = ({1'b0, bus.iX} >= X_LO) && ({1'b0, bus.iX} < X_HI) &&
                 ({1'b0, bus.iY} >= Y_LO) && ({1'b0, bus.iY} < Y_HI);
      col      = dx[5:2];
      row      = dy[5:2];
      accept   = (state == ST_CAPTURE) && bus.iPix_valid && in_win;
      cell_end = (dx[1:0] == 2'b11) && (dy[1:0] == 2'b11);
      last_pix = (dx == 10'd43) && (dy == 10'd43);
      // a frame start landing on the final pixel counts as completion, not restart
      restart  = (state == ST_CAPTURE) && bus.iVsync && !(accept && last_pix);
      take     = accept && !restart;
      clear_acc = (state == ST_WAIT_FRM) || restart;
`ifdef NUMERO_CAPTURE_INVERT_EN
      pix_val  = 8'd255 - bus.iPix;
`else
      pix_val  = bus.iPix;
`endif
      acc_sel = '0;
      for (int c = 0; c < 11; c++) begin
         if (col == 4'(c)) acc_sel = acc[c];
      end
      sum = acc_sel + {4'd0, pix_val};
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: if (bus.iStart) state_nxt = ST_WAIT_FRM;
         ST_WAIT_FRM:      if (bus.iVsync) state_nxt = ST_CAPTURE;
         ST_CAPTURE:       if (accept && last_pix) state_nxt = ST_DONE;
         default:          state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // one accumulator per cell column; raster order finishes a cell row before the next starts
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         for (int c = 0; c < 11; c++) acc[c] <= '0;
      end else begin
         for (int c = 0; c < 11; c++) begin
            if (clear_acc)
               acc[c] <= '0;
            else if (take && col == 4'(c))
               acc[c] <= cell_end ? 12'd0 : sum;
         end
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         numero <= '0;
      end else begin
         for (int r = 0; r < 11; r++) begin
            for (int c = 0; c < 11; c++) begin
               if (take && cell_end && row == 4'(r) && col == 4'(c))
                  numero[r][c] <= sum[11:4];
            end
         end
      end
   end

   assign bus.oNumero = numero;
   assign bus.oBusy   = (state == ST_WAIT_FRM) || (state == ST_CAPTURE);
   assign bus.oValid  = (state == ST_DONE);

endmodule
